// File: rtl/id_ctrl_stage_if.sv
// Decode-stage to ID/EX control bundle: decoded fields, pipeline controls and registered outputs.
interface id_ctrl_stage_if #(
   parameter int EXE_CMD_W = 4
);
   logic                 valid_in;
   logic [1:0]           mode;
   logic [3:0]           opcode;
   logic                 s;
   logic [3:0]           cond;
   logic [3:0]           status;
   logic                 stall_in;
   logic                 flush_in;
   logic [EXE_CMD_W-1:0] exe_cmd;
   logic                 mem_read;
   logic                 mem_write;
   logic                 wb_enable;
   logic                 branch_taken;
   logic                 status_write_enable;
   logic                 valid_out;
   logic                 busy;

   modport master (
      output valid_in, mode, opcode, s, cond, status, stall_in, flush_in,
      input  exe_cmd, mem_read, mem_write, wb_enable, branch_taken,
             status_write_enable, valid_out, busy
   );

   modport slave (
      input  valid_in, mode, opcode, s, cond, status, stall_in, flush_in,
      output exe_cmd, mem_read, mem_write, wb_enable, branch_taken,
             status_write_enable, valid_out, busy
   );
endinterface

// File: rtl/id_ctrl_stage.sv
// Registered ID-stage control decoder with ARM condition gating and an ID/EX control
// register supporting stall, flush and a multi-cycle hold after memory ops.
//
// state       | meaning
// ST_IDLE     | register loads a new decode unless stalled or flushed
// ST_MEM_HOLD | memory op held in the register for MEM_WAIT further cycles
module id_ctrl_stage #(
   parameter int EXE_CMD_W = 4,
   parameter int MEM_WAIT  = 2
) (
   input  logic            clk,
   input  logic            rst,
   id_ctrl_stage_if.slave  bus
);

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MEM_HOLD = 1'b1
   } state_t;

   typedef struct packed {
      logic [EXE_CMD_W-1:0] exe_cmd;
      logic                 mem_read;
      logic                 mem_write;
      logic                 wb_enable;
      logic                 branch_taken;
      logic                 status_write_enable;
      logic                 valid_out;
   } ctrl_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   ctrl_t      ctrl_q, ctrl_d;
   logic       busy_q, busy_d;
   ctrl_t      dec;
   logic       cond_pass;
   logic       load;

   logic flag_n, flag_z, flag_c, flag_v;
   assign {flag_n, flag_z, flag_c, flag_v} = bus.status;

   always_comb begin
      cond_pass = 1'b0;
      case (bus.cond)
         4'b0000: cond_pass = flag_z;
         4'b0001: cond_pass = !flag_z;
         4'b0010: cond_pass = flag_c;
         4'b0011: cond_pass = !flag_c;
         4'b0100: cond_pass = flag_n;
         4'b0101: cond_pass = !flag_n;
         4'b0110: cond_pass = flag_v;
         4'b0111: cond_pass = !flag_v;
         4'b1000: cond_pass = flag_c && !flag_z;
         4'b1001: cond_pass = !flag_c || flag_z;
         4'b1010: cond_pass = (flag_n == flag_v);
         4'b1011: cond_pass = (flag_n != flag_v);
         4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
         4'b1101: cond_pass = flag_z || (flag_n != flag_v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Bubbles carry valid_out=0; NOPs (unknown opcode, reserved mode) keep valid_out=1.
   always_comb begin
      dec = '0;
      if (bus.valid_in && cond_pass) begin
         dec.valid_out = 1'b1;
         case (bus.mode)
            2'b00: begin
               case (bus.opcode)
                  4'b1101: begin dec.exe_cmd = EXE_CMD_W'(4'b0001); dec.wb_enable = 1'b1; dec.status_write_enable = bus.s; end
                  4'b1111: begin dec.exe_cmd = EXE_CMD_W'(4'b1001); dec.wb_enable = 1'b1; dec.status_write_enable = bus.s; end
                  4'b0100: begin dec.exe_cmd = EXE_CMD_W'(4'b0010); dec.wb_enable = 1'b1; dec.status_write_enable = bus.s; end
                  4'b0101: begin dec.exe_cmd = EXE_CMD_W'(4'b0011); dec.wb_enable = 1'b1; dec.status_write_enable = bus.s; end
                  4'b0010: begin dec.exe_cmd = EXE_CMD_W'(4'b0100); dec.wb_enable = 1'b1; dec.status_write_enable = bus.s; end
                  4'b0110: begin dec.exe_cmd = EXE_CMD_W'(4'b0101); dec.wb_enable = 1'b1; dec.status_write_enable = bus.s; end
                  4'b0000: begin dec.exe_cmd = EXE_CMD_W'(4'b0110); dec.wb_enable = 1'b1; dec.status_write_enable = bus.s; end
                  4'b1100: begin dec.exe_cmd = EXE_CMD_W'(4'b0111); dec.wb_enable = 1'b1; dec.status_write_enable = bus.s; end
                  4'b0001: begin dec.exe_cmd = EXE_CMD_W'(4'b1000); dec.wb_enable = 1'b1; dec.status_write_enable = bus.s; end
                  4'b1010: begin dec.exe_cmd = EXE_CMD_W'(4'b0100); dec.status_write_enable = 1'b1; end
                  4'b1000: begin dec.exe_cmd = EXE_CMD_W'(4'b0110); dec.status_write_enable = 1'b1; end
                  default: ;
               endcase
            end
            2'b01: begin
               dec.exe_cmd   = EXE_CMD_W'(4'b0010);
               dec.mem_read  = bus.s;
               dec.mem_write = !bus.s;
               dec.wb_enable = bus.s;
            end
            2'b10:   dec.branch_taken = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      if (bus.flush_in) begin
         state_d = ST_IDLE;
         cnt_d   = 4'd0;
      end else if (state_q == ST_MEM_HOLD) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            state_d = ST_IDLE;
         end
      end else if (!bus.stall_in) begin
         load = 1'b1;
         if ((dec.mem_read || dec.mem_write) && (MEM_WAIT > 0)) begin
            state_d = ST_MEM_HOLD;
            cnt_d   = 4'(MEM_WAIT);
         end
      end
   end

   // busy lags the hold state by one cycle so it spans the last MEM_WAIT cycles of the op.
   always_comb begin
      ctrl_d = ctrl_q;
      busy_d = (state_q == ST_MEM_HOLD) && !bus.flush_in;
      if (bus.flush_in) begin
         ctrl_d = '0;
      end else if (load) begin
         ctrl_d = dec;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= '0;
         busy_q <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         busy_q <= busy_d;
      end
   end

   assign bus.exe_cmd             = ctrl_q.exe_cmd;
   assign bus.mem_read            = ctrl_q.mem_read;
   assign bus.mem_write           = ctrl_q.mem_write;
   assign bus.wb_enable           = ctrl_q.wb_enable;
   assign bus.branch_taken        = ctrl_q.branch_taken;
   assign bus.status_write_enable = ctrl_q.status_write_enable;
   assign bus.valid_out           = ctrl_q.valid_out;
   assign bus.busy                = busy_q;

endmodule
